// File: rtl/branch_tag_mgr.sv
// rtl/branch_tag_mgr.sv - branch tag allocator with misprediction flush and fetch redirect
module branch_tag_mgr #(
    parameter int branch_addr = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alloc_req,
    output logic                   alloc_gnt,
    output logic [2:0]             alloc_bid,
    input  logic                   resolve_valid,
    input  logic [2:0]             resolve_bid,
    input  logic                   flush,
    input  logic [2:0]             flush_bid,
    input  logic [branch_addr-1:0] flush_addr,
    output logic                   redirect_valid,
    output logic [branch_addr-1:0] redirect_addr,
    output logic [7:0]             kill_mask,
    output logic                   flush_err,
    output logic [3:0]             count,
    output logic                   full,
    output logic                   empty
);

    // Window depth is tied to the 3-bit tag width, so it is not a parameter.
    localparam int num_tags = 8;

    logic [2:0]             r_head;
    logic [2:0]             r_tail;
    logic [3:0]             r_count;
    logic [7:0]             r_inflight;
    logic [7:0]             r_resolved;
    logic                   r_redirect_valid;
    logic [branch_addr-1:0] r_redirect_addr;
    logic [7:0]             r_kill_mask;
    logic                   r_flush_err;

    logic                   w_full;
    logic                   w_alloc_gnt;
    logic                   w_flush_ok;
    logic                   w_flush_bad;
    logic                   w_retire;
    logic [2:0]             w_bpos;
    logic [2:0]             w_pos [num_tags];
    logic [7:0]             w_kill;
    logic [2:0]             w_head_nxt;
    logic [2:0]             w_tail_nxt;
    logic [3:0]             w_count_nxt;
    logic [7:0]             w_inflight_nxt;
    logic [7:0]             w_resolved_nxt;

    assign w_full      = (r_count == 4'd8);
    assign w_alloc_gnt = alloc_req & ~w_full & ~flush;
    assign w_flush_ok  = flush & r_inflight[flush_bid];
    assign w_flush_bad = flush & ~r_inflight[flush_bid];
    assign w_retire    = (r_count != 4'd0) & r_resolved[r_head];
    assign w_bpos      = flush_bid - r_head;

    assign alloc_gnt      = w_alloc_gnt;
    assign alloc_bid      = r_tail;
    assign count          = r_count;
    assign full           = w_full;
    assign empty          = (r_count == 4'd0);
    assign redirect_valid = r_redirect_valid;
    assign redirect_addr  = r_redirect_addr;
    assign kill_mask      = r_kill_mask;
    assign flush_err      = r_flush_err;

    // Kill set: in-flight tags whose age position from head is past the flushed tag.
    always_comb begin
        w_kill = '0;
        for (int t = 0; t < num_tags; t++) begin
            w_pos[t]  = 3'(t) - r_head;
            w_kill[t] = w_flush_ok && (w_pos[t] > w_bpos) && ({1'b0, w_pos[t]} < r_count);
        end
    end

    // Next window state: resolve, then flush or allocate, then retire at head.
    always_comb begin
        w_head_nxt     = r_head;
        w_tail_nxt     = r_tail;
        w_count_nxt    = r_count;
        w_inflight_nxt = r_inflight;
        w_resolved_nxt = r_resolved;
        if (resolve_valid && r_inflight[resolve_bid] && !w_kill[resolve_bid]) begin
            w_resolved_nxt[resolve_bid] = 1'b1;
        end
        if (w_flush_ok) begin
            w_inflight_nxt            = w_inflight_nxt & ~w_kill;
            w_resolved_nxt            = w_resolved_nxt & ~w_kill;
            w_resolved_nxt[flush_bid] = 1'b1;
            w_tail_nxt                = flush_bid + 3'd1;
            w_count_nxt               = {1'b0, w_bpos} + 4'd1;
        end else if (w_alloc_gnt) begin
            w_inflight_nxt[r_tail] = 1'b1;
            w_resolved_nxt[r_tail] = 1'b0;
            w_tail_nxt             = r_tail + 3'd1;
            w_count_nxt            = r_count + 4'd1;
        end
        // A flushed tag that is already at head and resolved retires normally here.
        if (w_retire) begin
            w_inflight_nxt[r_head] = 1'b0;
            w_resolved_nxt[r_head] = 1'b0;
            w_head_nxt             = r_head + 3'd1;
            w_count_nxt            = w_count_nxt - 4'd1;
        end
    end

    // Window state and one-cycle redirect/kill/error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head           <= '0;
            r_tail           <= '0;
            r_count          <= '0;
            r_inflight       <= '0;
            r_resolved       <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_addr  <= '0;
            r_kill_mask      <= '0;
            r_flush_err      <= 1'b0;
        end else begin
            r_head           <= w_head_nxt;
            r_tail           <= w_tail_nxt;
            r_count          <= w_count_nxt;
            r_inflight       <= w_inflight_nxt;
            r_resolved       <= w_resolved_nxt;
            r_redirect_valid <= w_flush_ok;
            r_kill_mask      <= w_kill;
            r_flush_err      <= w_flush_bad;
            if (w_flush_ok) begin
                r_redirect_addr <= flush_addr;
            end
        end
    end

endmodule

// File: doc/branch_tag_mgr.md
# branch_tag_mgr

Branch tag allocator and misprediction recovery stage, sitting directly downstream of the branch resolution unit (the four-slot compare/priority/mux block). It hands out 3-bit branch IDs to dispatched branches in program order, tracks them in an 8-entry circular window, and retires them as they resolve. When the resolution unit raises `flush` with a `bid` and target `addr`, this block:

- squashes every tag younger than that `bid`;
- issues a registered one-cycle fetch redirect plus a kill mask for the issue queues.

## Interface
Parameters:
- `branch_addr`, default 5: width of the redirect target address.
- `num_tags`, fixed 8: tag window depth. Tag width is 3 bits; this parameter is not overridable.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `alloc_req`  in  1  dispatch requests a tag for a new branch.
- `alloc_gnt`  out  1  combinational: `alloc_req & ~full & ~flush`.
- `alloc_bid`  out  3  combinational: the tag granted this cycle, equal to `tail`.
- `resolve_valid`  in  1  a branch resolved correctly (no misprediction).
- `resolve_bid`  in  3  tag of the correctly resolved branch.
- `flush`  in  1  misprediction, from the resolution unit.
- `flush_bid`  in  3  tag of the mispredicted branch.
- `flush_addr`  in  `branch_addr`  correct target address.
- `redirect_valid`  out  1  registered one-cycle pulse to fetch.
- `redirect_addr`  out  `branch_addr`  registered target; holds its value between pulses.
- `kill_mask`  out  8  registered one-cycle bitmask of squashed tags.
- `flush_err`  out  1  registered pulse: `flush_bid` was not in flight.
- `count`  out  4  number of in-flight tags (0..8).
- `full`  out  1  `count == 8`.
- `empty`  out  1  `count == 0`.

## Operation
State:
- `head` (3 bits): oldest in-flight tag.
- `tail` (3 bits): next tag to allocate.
- `count` (4 bits).
- `inflight[7:0]` and `resolved[7:0]` bitmaps.

A tag `t` is in flight iff `inflight[t]`. Tag order is modular from `head`. "Younger than `b`" means modular position `(t - head) mod 8` greater than `(b - head) mod 8` and less than `count`.

Rules:
- **Allocate:** when `alloc_gnt`, set `inflight[tail]`, clear `resolved[tail]`, and `tail <= tail+1` (wraps 7 -> 0).
- **Resolve:** when `resolve_valid` and `inflight[resolve_bid]`, set `resolved[resolve_bid]`. A resolve for a tag that is not in flight is ignored silently.
- **Retire:** each cycle, if `count > 0` and `resolved[head]`, clear `inflight[head]` and `resolved[head]`, and `head <= head+1`. At most one retire per cycle.
- **Flush with valid tag** (`flush` and `inflight[flush_bid]`):
  - Clear `inflight` for all tags younger than `flush_bid`.
  - Set `resolved[flush_bid]`.
  - `tail <= flush_bid+1`.
  - Next cycle: `kill_mask` = those tags, `redirect_valid = 1`, `redirect_addr = flush_addr`.
- **Flush with invalid tag** (`flush` and `!inflight[flush_bid]`): no state change; next cycle `flush_err = 1`, with `redirect_valid = 0` and `kill_mask = 0`.
- **`count` update:** `count_next = count + alloc - retire` normally. On a valid flush, `count_next = ((flush_bid - head) mod 8) + 1 - retire`.
- **Simultaneous events:**
  - Flush blocks alloc, since `alloc_gnt` is 0.
  - A resolve in the flush cycle is applied only if its tag is not killed.
  - A retire in the flush cycle proceeds normally. The flushed tag itself is retired on a later cycle, once it is at `head`.
- **Wrap-around:** with `head = 6` and `count = 4`, the in-flight tags are 6, 7, 0, 1, and `tail = 2`.

## Timing
- **Reset:** while `rst` is high, asynchronously: `head = 0`, `tail = 0`, `count = 0`, `inflight = 0`, `resolved = 0`, `redirect_valid = 0`, `redirect_addr = 0`, `kill_mask = 0`, `flush_err = 0`. Hence `full = 0`, `empty = 1`, `alloc_bid = 0`.
- **Reset mid-operation:** all in-flight tags are discarded. No redirect or kill is emitted for them.
- **Alloc:** zero-latency grant. The tag is visible as in flight from the next cycle.
- **Flush to redirect/kill:** exactly 1 cycle. Each output pulse lasts exactly 1 cycle.
- **Back-to-back flushes:** consecutive flush cycles produce consecutive pulses. The second is evaluated against state already updated by the first.
- **Resolve to retire:** at least 1 cycle, since the retire check uses registered `resolved`.

## Test plan
1. **Reset and fill:** reset, then 8 consecutive `alloc_req` -> `alloc_bid` 0..7, `full = 1` after the 8th. A 9th request -> `alloc_gnt = 0`.
2. **In-order retire:** allocate 0..2, resolve 0, 1, 2 on successive cycles -> `count` returns to 0, `head = tail = 3`, `empty = 1`.
3. **Flush mid-window:** allocate 0..4, `flush` with `bid = 1`, `addr = 5'h1A` -> next cycle `redirect_valid = 1`, `redirect_addr = 5'h1A`, `kill_mask = 8'b0001_1100`; `tail = 2`; the following `alloc_bid = 2`.
4. **Wrap-around flush:** with `head = 6` and tags 6, 7, 0, 1 in flight, flush `bid = 7` -> `kill_mask = 8'b0000_0011`, `count = 2`, `tail = 0`.
5. **Simultaneous events:** in one cycle, flush `bid = 2` with `alloc_req = 1` and resolve `bid = 4` (0..4 in flight) -> `alloc_gnt = 0`, tag 4 killed rather than resolved, `flush_err = 0`. Separately, flush `bid = 6` when not in flight -> `flush_err` pulse, no redirect.
6. **Async reset during flush:** assert `rst` in the cycle after a flush -> `redirect_valid` drops to 0 immediately and all counters are 0.
